// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, datapath widths and reset PC.
package cpu_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MEM_ADDR_W = 16;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'd0;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// Loadable down-counter with a zero flag; times fixed-latency memory reads.
module fetch_wait_timer
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (load) begin
        cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues fixed-latency word reads, hands instructions
// to the decoder over valid/ready. Define FETCH_COUNT_EN to build the accepted-instruction counter.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       MEM_LATENCY = 3,
  parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  redirect_valid,
  input  logic [WORD_W-1:0]     redirect_pc,
  input  logic                  instr_ready,
  output logic                  instr_valid,
  output logic [WORD_W-1:0]     instr,
  output logic [WORD_W-1:0]     instr_pc,
  output logic [WORD_W-1:0]     pc_plus1,
  output logic                  mem_en,
  output logic                  mem_ren,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0]     mem_dout,
  output logic                  busy,
  output logic [CNT_W-1:0]      fetch_count
);

  localparam int unsigned      TMR_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(MEM_LATENCY - 1);

  fetch_state_t          state_q, state_d;
  logic [WORD_W-1:0]     pc_q, pc_d;
  logic [WORD_W-1:0]     instr_q, instr_d;
  logic [WORD_W-1:0]     instr_pc_q, instr_pc_d;
  logic [WORD_W-1:0]     pc_plus1_q, pc_plus1_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_ren_q, mem_ren_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;
  logic                  tmr_load, tmr_dec, tmr_done;
  logic                  handshake;

  // A handshake still counts when a redirect lands in the same cycle.
  assign handshake = en && (state_q == HOLD) && instr_valid_q && instr_ready;

  fetch_wait_timer #(
    .CNT_W (TMR_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (tmr_load),
    .load_val (WAIT_LOAD),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc_plus1_d    = pc_plus1_q;
    instr_valid_d = instr_valid_q;
    mem_en_d      = mem_en_q;
    mem_ren_d     = mem_ren_q;
    mem_addr_d    = mem_addr_q;
    busy_d        = busy_q;
    tmr_load      = 1'b0;
    tmr_dec       = 1'b0;
    if (en) begin
      if (redirect_valid) begin
        pc_d          = redirect_pc;
        instr_valid_d = 1'b0;
        mem_en_d      = 1'b0;
        mem_ren_d     = 1'b0;
        state_d       = ISSUE;
      end else begin
        unique case (state_q)
          ISSUE: begin
            mem_en_d   = 1'b1;
            mem_ren_d  = 1'b1;
            mem_addr_d = pc_q[MEM_ADDR_W-1:0];
            tmr_load   = 1'b1;
            state_d    = WAIT;
          end
          WAIT: begin
            if (tmr_done) begin
              instr_d       = mem_dout;
              instr_pc_d    = pc_q;
              pc_plus1_d    = pc_q + 32'd1;
              instr_valid_d = 1'b1;
              mem_en_d      = 1'b0;
              mem_ren_d     = 1'b0;
              state_d       = HOLD;
            end else begin
              tmr_dec = 1'b1;
            end
          end
          HOLD: begin
            if (handshake) begin
              instr_valid_d = 1'b0;
              pc_d          = pc_q + 32'd1;
              state_d       = ISSUE;
            end
          end
          default: state_d = ISSUE;
        endcase
      end
      busy_d = (state_d != HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ISSUE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      pc_plus1_q    <= '0;
      instr_valid_q <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_ren_q     <= 1'b0;
      mem_addr_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      pc_plus1_q    <= pc_plus1_d;
      instr_valid_q <= instr_valid_d;
      mem_en_q      <= mem_en_d;
      mem_ren_q     <= mem_ren_d;
      mem_addr_q    <= mem_addr_d;
      busy_q        <= busy_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus1    = pc_plus1_q;
  assign mem_en      = mem_en_q;
  assign mem_ren     = mem_ren_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = busy_q;

`ifdef FETCH_COUNT_EN
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (handshake) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: transaction-level PC/latency model plus random traffic.
module tb_fetch_unit;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, pc_plus1, mem_dout, fetch_count;
  logic        mem_en, mem_ren, busy;
  logic [15:0] mem_addr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    if (a == 16'd0) return 32'h2008_0005;
    if (a == 16'd1) return 32'h2009_0007;
    return ({16'd0, a} * 32'h9E37_79B1) ^ 32'h0000_A5A5;
  endfunction

  assign mem_dout = (mem_en && mem_ren) ? memf(mem_addr) : 32'hDEAD_BEEF;

  fetch_unit #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .pc_plus1(pc_plus1),
    .mem_en(mem_en), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .busy(busy), .fetch_count(fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: counts enabled edges; a fetch started at edge k delivers at edge k+L+1.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          ecnt = 0;
  int          cyc = 0;
  int          m_due = L + 1;
  logic [31:0] m_pc = '0;
  logic [31:0] m_count = '0;
  bit          m_hold = 0;

  always @(posedge clk) begin
    exp_t t;
    cyc++;
    if (!rst_n) begin
      ecnt = 0; m_pc = 32'd0; m_due = L + 1; m_hold = 0; m_count = '0;
      sbq.delete();
    end else if (en) begin
      ecnt++;
      if (m_hold && instr_ready) m_count = m_count + 1;
      if (redirect_valid) begin
        m_pc = redirect_pc; m_due = ecnt + L + 1; m_hold = 0;
      end else if (m_hold) begin
        if (instr_ready) begin
          m_pc = m_pc + 1; m_due = ecnt + L + 1; m_hold = 0;
        end
      end else if (ecnt == m_due) begin
        t.pc = m_pc; t.word = memf(m_pc[15:0]); t.due = ecnt;
        sbq.push_back(t);
        m_hold = 1;
      end
    end
  end

  function automatic logic [31:0] exp_count();
`ifdef FETCH_COUNT_EN
    return m_count;
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: pops on each new instruction, checks hold stability and read issue.
  exp_t cur;
  bit   prev_v = 0, prev_men = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0; prev_men = 0;
    end else begin
      if (instr_valid && !prev_v) begin
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL unexpected_valid: instr_pc %h presented, expected no instruction", instr_pc);
        end else begin
          cur = sbq.pop_front();
          chk("instr_pc", instr_pc, cur.pc);
          chk("instr", instr, cur.word);
          chk("pc_plus1", pc_plus1, cur.pc + 32'd1);
          chk("latency_edge", ecnt, cur.due);
          chk("busy_in_hold", {31'd0, busy}, 32'd0);
          chk("fetch_count", fetch_count, exp_count());
        end
      end else if (instr_valid && prev_v) begin
        chk("hold_instr", instr, cur.word);
        chk("hold_pc", instr_pc, cur.pc);
        chk("hold_mem_en", {31'd0, mem_en}, 32'd0);
      end
      if (mem_en && !prev_men) begin
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_pc[15:0]});
        chk("mem_ren", {31'd0, mem_ren}, 32'd1);
        chk("busy_in_read", {31'd0, busy}, 32'd1);
      end
      prev_v = instr_valid; prev_men = mem_en;
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 100) begin @(negedge clk); n++; end
    if (!instr_valid) begin
      total++;
      $display("FAIL %s_timeout: instr_valid low after %0d cycles, expected high", name, n);
    end
  endtask

  task automatic wait_new_valid(input string name);
    int n = 0;
    while (instr_valid && n < 50) begin @(negedge clk); n++; end
    wait_valid(name);
  endtask

  task automatic wait_mem_en_rise(input string name);
    int n = 0;
    while (mem_en && n < 50) begin @(negedge clk); n++; end
    while (!mem_en && n < 100) begin @(negedge clk); n++; end
    if (!mem_en) begin
      total++;
      $display("FAIL %s_timeout: mem_en low after %0d cycles, expected high", name, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c0, fc0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_pc_plus1", pc_plus1, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);

    // First fetches after reset release, ready tied high
    rst_n = 1; en = 1; instr_ready = 1;
    wait_valid("t1a");
    c1 = cyc;
    chk("t1_first_instr", instr, 32'h2008_0005);
    chk("t1_first_pc", instr_pc, 32'd0);
    chk("t1_first_latency", ecnt, 32'd4);
    wait_new_valid("t1b");
    chk("t1_second_pc", instr_pc, 32'd1);
    chk("t1_second_instr", instr, 32'h2009_0007);
    chk("t1_period", cyc - c1, 32'd5);

    // Backpressure for 10 cycles
    instr_ready = 0;
    repeat (10) begin
      @(negedge clk);
      chk("t2_valid_held", {31'd0, instr_valid}, 32'd1);
    end
    instr_ready = 1;
    wait_new_valid("t2");
    chk("t2_next_pc", instr_pc, 32'd2);

    // Redirect during the second WAIT cycle
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 0;
    wait_new_valid("t3");
    chk("t3_redirect_pc", instr_pc, 32'h40);

    // Redirect and handshake together in HOLD
    instr_ready = 0; redirect_valid = 1; redirect_pc = 32'd5;
    @(negedge clk);
    redirect_valid = 0;
    wait_new_valid("t4a");
    chk("t4_hold_pc", instr_pc, 32'd5);
    fc0 = m_count;
    instr_ready = 1; redirect_valid = 1; redirect_pc = 32'd9;
    @(negedge clk);
    redirect_valid = 0;
`ifdef FETCH_COUNT_EN
    chk("t4_count_inc", fetch_count, fc0 + 32'd1);
`else
    chk("t4_count_tied", fetch_count, 32'd0);
`endif
    wait_valid("t4b");
    chk("t4_next_pc", instr_pc, 32'd9);

    // Enable low for 5 cycles mid-WAIT
    @(negedge clk);
    c0 = cyc;
    @(negedge clk);
    @(negedge clk);
    en = 0;
    repeat (5) @(negedge clk);
    chk("t5_mem_en_frozen", {31'd0, mem_en}, 32'd1);
    chk("t5_busy_frozen", {31'd0, busy}, 32'd1);
    en = 1;
    wait_valid("t5");
    chk("t5_delay", cyc - c0, L + 1 + 5);
    chk("t5_pc", instr_pc, 32'd10);

    // Address wrap at 64K words and full 32-bit PC wrap
    redirect_valid = 1; redirect_pc = 32'h0001_FFFF;
    @(negedge clk);
    redirect_valid = 0;
    wait_mem_en_rise("t6a");
    chk("t6_addr_ffff", {16'd0, mem_addr}, 32'h0000_FFFF);
    wait_valid("t6b");
    chk("t6_plus1", pc_plus1, 32'h0002_0000);
    wait_mem_en_rise("t6c");
    chk("t6_addr_wrap", {16'd0, mem_addr}, 32'd0);
    wait_new_valid("t6d");
    chk("t6_pc_after", instr_pc, 32'h0002_0000);
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_valid = 0;
    wait_new_valid("t6e");
    chk("t6_pc32_plus1", pc_plus1, 32'd0);
    wait_new_valid("t6f");
    chk("t6_pc32_wrap", instr_pc, 32'd0);

    // Reset in the middle of a read
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("t7_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("t7_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("t7_rst_instr", instr, 32'd0);
    @(negedge clk);
    rst_n = 1;
    wait_valid("t7");
    chk("t7_restart_pc", instr_pc, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      en             = ($urandom_range(0, 9) != 0);
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 31))
                                                   : $urandom;
    end
    @(negedge clk);
    en = 1; redirect_valid = 0; instr_ready = 1;
    repeat (20) @(negedge clk);
    chk("end_fetch_count", fetch_count, exp_count());
    chk("end_scoreboard_empty", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
